rob_queue_ctrl: RTL and testbench
=================================

Name: rob_queue_ctrl

Overview:
- Sequencing controller that turns one external circular queue instance into an in-order reorder buffer.
- Dispatch allocates an entry at the queue tail and returns the tail index as the tag.
- Two writeback units share the queue's single probe port through a round-robin arbiter, using a read-modify-write to mark entries done.
- In-order commit pops the head only when its done bit is set; a flush request sequences a queue flush and a recovery bubble.

Parameters:
- ADDR_WIDTH, 4, queue index width; depth = 2^ADDR_WIDTH.
- DEST_W, 5, destination-register field width.
- RES_W, 8, result field width.
- Entry width EW = 1+DEST_W+RES_W (derived). Entry layout {done, dest, result}.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- disp_valid  in  1  dispatch request
- disp_dest  in  DEST_W  destination of dispatched op
- disp_ready  out  1  entry allocated this cycle when disp_valid&disp_ready
- disp_tag  out  ADDR_WIDTH  allocated index (= q_tail)
- wb0_valid, wb1_valid  in  1  writeback requests
- wb0_tag, wb1_tag  in  ADDR_WIDTH  target entry
- wb0_result, wb1_result  in  RES_W  result value
- wb0_ack, wb1_ack  out  1  writeback accepted this cycle
- wb_err  out  1  registered one-cycle pulse: granted tag not occupied, write dropped
- commit_valid  out  1  head entry done and committable
- commit_ready  in  1  consumer accepts commit
- commit_dest  out  DEST_W  head dest
- commit_result  out  RES_W  head result
- commit_count  out  16  registered count of commits, wraps at 0xFFFF→0
- flush_req  in  1  mispredict/exception flush request
- busy_flush  out  1  high in FLUSH or RECOVER
- q_push, q_pop, q_flush, q_probe_push  out  1  queue controls
- q_data, q_probe_din  out  EW  queue write data
- q_dout, q_probe_dout  in  EW  queue head data / probe read data (combinational)
- q_probe_idx  out  ADDR_WIDTH  probe index
- q_empty, q_full  in  1  queue flags
- q_head, q_tail  in  ADDR_WIDTH  queue pointers

Behaviour:
- reset low at posedge: state=RUN, rr=0, commit_count=0, wb_err=0. While reset is low, every handshake and queue-control output is forced to 0.
- FSM RUN → FLUSH when flush_req=1. FLUSH → RECOVER unconditionally. RECOVER → RUN unconditionally. flush_req is ignored outside RUN.
- gate = (state==RUN) && !flush_req. All of disp_ready, wbN_ack, commit_valid, q_push, q_pop and q_probe_push are ANDed with gate.
- q_flush=1 only in FLUSH (exactly one cycle). busy_flush=1 in FLUSH and RECOVER.
- Dispatch: disp_ready = gate & !q_full. q_push = disp_valid & disp_ready. q_data = {0, disp_dest, 0}. disp_tag = q_tail. Zero latency: the queue writes at the same edge.
- Occupancy: cnt = q_full ? 2^ADDR_WIDTH : (q_tail - q_head) mod 2^ADDR_WIDTH. A tag is occupied iff ((tag - q_head) mod 2^ADDR_WIDTH) < cnt.
- Arbiter:
  - Both wb valid → grant wb[rr].
  - One valid → grant that one.
  - After any grant, rr <= index of the non-granted unit.
  - Grant only when gate; wbN_ack = grant to N.
- Writeback RMW:
  - q_probe_idx = granted tag.
  - If occupied: q_probe_push=1, q_probe_din = {1, q_probe_dout.dest, granted result}.
  - Otherwise: q_probe_push=0, ack still given, wb_err<=1 next cycle.
  - wb_err is 0 in any cycle following no error.
- Commit:
  - commit_valid = gate & !q_empty & q_dout.done. commit_dest/commit_result are fields of q_dout.
  - q_pop = commit_valid & commit_ready. commit_count increments on each pop.
- Simultaneous events:
  - Writeback to the head entry in the same cycle does not make it committable until the next cycle.
  - Dispatch and commit in the same cycle are both allowed; at full, the pop does not enable push (disp_ready uses q_full).
  - Writeback and dispatch on the same cycle are independent ports.
- Wrap-around: tags and occupancy use modulo-2^ADDR_WIDTH arithmetic. Entry index 2^ADDR_WIDTH-1 followed by 0 must work.
- A reset during FLUSH or RECOVER returns the FSM to RUN with no residual q_flush.

Test Plan:
- Reset, then dispatch dests 1,2,3 → tags 0,1,2. wb1 tag1 result 0xAA → no commit (head not done). wb0 tag0 0x55 → commit (1,0x55) then (2,0xAA). commit_count=2.
- wb0 and wb1 both valid on occupied tags for 3 cycles, rr=0 → acks wb0, wb1, wb0.
- Fill 16 entries → disp_ready=0 on 17th request. Commit one with dispatch held → next cycle disp_ready=1 and tag = old head index.
- Dispatch 20 with commits interleaved so tail wraps 15→0. wb to tag 0 after wrap is accepted; wb to an unoccupied tag → ack=1, wb_err pulse, no entry change.
- flush_req with 5 entries → q_flush high exactly the next cycle. disp_ready/commit_valid/acks low for 3 cycles total. Queue empty, tag 0 on the next dispatch.
- reset asserted in FLUSH → next cycle state RUN, busy_flush=0, commit_count=0.

Source files
------------

// File: rtl/rob_queue_ctrl.sv
// Reorder-buffer sequencer on top of an external circular queue: in-order dispatch/commit,
// two round-robin arbitrated writeback units sharing the queue probe port, and a flush sequence.
module rob_queue_ctrl #(
    parameter int ADDR_WIDTH = 4,
    parameter int DEST_W     = 5,
    parameter int RES_W      = 8,
    localparam int EW        = 1 + DEST_W + RES_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  disp_valid,
    input  logic [DEST_W-1:0]     disp_dest,
    output logic                  disp_ready,
    output logic [ADDR_WIDTH-1:0] disp_tag,
    input  logic                  wb0_valid,
    input  logic [ADDR_WIDTH-1:0] wb0_tag,
    input  logic [RES_W-1:0]      wb0_result,
    output logic                  wb0_ack,
    input  logic                  wb1_valid,
    input  logic [ADDR_WIDTH-1:0] wb1_tag,
    input  logic [RES_W-1:0]      wb1_result,
    output logic                  wb1_ack,
    output logic                  wb_err,
    output logic                  commit_valid,
    input  logic                  commit_ready,
    output logic [DEST_W-1:0]     commit_dest,
    output logic [RES_W-1:0]      commit_result,
    output logic [15:0]           commit_count,
    input  logic                  flush_req,
    output logic                  busy_flush,
    output logic                  q_push,
    output logic                  q_pop,
    output logic                  q_flush,
    output logic                  q_probe_push,
    output logic [EW-1:0]         q_data,
    output logic [EW-1:0]         q_probe_din,
    input  logic [EW-1:0]         q_dout,
    input  logic [EW-1:0]         q_probe_dout,
    output logic [ADDR_WIDTH-1:0] q_probe_idx,
    input  logic                  q_empty,
    input  logic                  q_full,
    input  logic [ADDR_WIDTH-1:0] q_head,
    input  logic [ADDR_WIDTH-1:0] q_tail
);

    typedef enum logic [1:0] {RUN, FLUSH, RECOVER} state_t;

    state_t state;
    logic flushR, busyR, rr, wbErrR;
    logic [15:0] commitCount;

    logic gate, grant0, grant1, anyGrant, occupied;
    logic [ADDR_WIDTH:0] cnt;
    logic [ADDR_WIDTH-1:0] gTag, headDist;
    logic [RES_W-1:0] gRes;
    logic unusedProbe;

    always_comb begin
        gate     = reset && (state == RUN) && !flush_req;
        // q_full disambiguates head==tail between empty and a full ring
        cnt      = q_full ? {1'b1, {ADDR_WIDTH{1'b0}}} : {1'b0, q_tail - q_head};
        grant0   = gate && wb0_valid && (!wb1_valid || !rr);
        grant1   = gate && wb1_valid && (!wb0_valid || rr);
        anyGrant = grant0 || grant1;
        gTag     = grant1 ? wb1_tag : wb0_tag;
        gRes     = grant1 ? wb1_result : wb0_result;
        headDist = gTag - q_head;
        occupied = {1'b0, headDist} < cnt;
    end

    assign disp_ready    = gate && !q_full;
    assign q_push        = disp_valid && disp_ready;
    assign q_data        = {1'b0, disp_dest, {RES_W{1'b0}}};
    assign disp_tag      = q_tail;

    assign wb0_ack       = grant0;
    assign wb1_ack       = grant1;
    assign q_probe_idx   = gTag;
    assign q_probe_push  = anyGrant && occupied;
    assign q_probe_din   = {1'b1, q_probe_dout[EW-2 -: DEST_W], gRes};
    assign wb_err        = wbErrR;
    assign unusedProbe   = ^{q_probe_dout[EW-1], q_probe_dout[RES_W-1:0]};

    assign commit_valid  = gate && !q_empty && q_dout[EW-1];
    assign commit_dest   = q_dout[EW-2 -: DEST_W];
    assign commit_result = q_dout[RES_W-1:0];
    assign q_pop         = commit_valid && commit_ready;
    assign commit_count  = commitCount;

    assign q_flush       = reset && flushR;
    assign busy_flush    = busyR;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= RUN;
            flushR      <= 1'b0;
            busyR       <= 1'b0;
            rr          <= 1'b0;
            wbErrR      <= 1'b0;
            commitCount <= '0;
        end else begin
            wbErrR <= anyGrant && !occupied;
            if (grant0)
                rr <= 1'b1;
            else if (grant1)
                rr <= 1'b0;
            if (q_pop)
                commitCount <= commitCount + 16'd1;
            case (state)
                RUN: if (flush_req) begin
                    state  <= FLUSH;
                    flushR <= 1'b1;
                    busyR  <= 1'b1;
                end
                FLUSH: begin
                    state  <= RECOVER;
                    flushR <= 1'b0;
                end
                RECOVER: begin
                    state <= RUN;
                    busyR <= 1'b0;
                end
                default: begin
                    state  <= RUN;
                    flushR <= 1'b0;
                    busyR  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rob_queue_ctrl.sv
// Bench for rob_queue_ctrl: a behavioural queue provides the external storage, and a
// list-of-entries ROB model predicts every controller output each cycle.
module tb_rob_queue_ctrl;

    localparam int AW = 4;
    localparam int DW = 5;
    localparam int RW = 8;
    localparam int EW = 1 + DW + RW;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic reset;
    logic disp_valid, disp_ready;
    logic [DW-1:0] disp_dest;
    logic [AW-1:0] disp_tag;
    logic wb0_valid, wb1_valid, wb0_ack, wb1_ack, wb_err;
    logic [AW-1:0] wb0_tag, wb1_tag;
    logic [RW-1:0] wb0_result, wb1_result;
    logic commit_valid, commit_ready;
    logic [DW-1:0] commit_dest;
    logic [RW-1:0] commit_result;
    logic [15:0] commit_count;
    logic flush_req, busy_flush;
    logic q_push, q_pop, q_flush, q_probe_push;
    logic [EW-1:0] q_data, q_probe_din, q_dout, q_probe_dout;
    logic [AW-1:0] q_probe_idx, q_head, q_tail;
    logic q_empty, q_full;

    always #5 clk = ~clk;

    rob_queue_ctrl #(.ADDR_WIDTH(AW), .DEST_W(DW), .RES_W(RW)) dut (
        .clk(clk), .reset(reset),
        .disp_valid(disp_valid), .disp_dest(disp_dest), .disp_ready(disp_ready), .disp_tag(disp_tag),
        .wb0_valid(wb0_valid), .wb0_tag(wb0_tag), .wb0_result(wb0_result), .wb0_ack(wb0_ack),
        .wb1_valid(wb1_valid), .wb1_tag(wb1_tag), .wb1_result(wb1_result), .wb1_ack(wb1_ack),
        .wb_err(wb_err),
        .commit_valid(commit_valid), .commit_ready(commit_ready), .commit_dest(commit_dest),
        .commit_result(commit_result), .commit_count(commit_count),
        .flush_req(flush_req), .busy_flush(busy_flush),
        .q_push(q_push), .q_pop(q_pop), .q_flush(q_flush), .q_probe_push(q_probe_push),
        .q_data(q_data), .q_probe_din(q_probe_din), .q_dout(q_dout), .q_probe_dout(q_probe_dout),
        .q_probe_idx(q_probe_idx), .q_empty(q_empty), .q_full(q_full), .q_head(q_head), .q_tail(q_tail)
    );

    // External circular queue driven only by the controller's queue-control outputs
    logic [EW-1:0] qMem [DEPTH];
    logic [AW-1:0] qHead, qTail;
    int qCnt;
    assign q_full       = (qCnt == DEPTH);
    assign q_empty      = (qCnt == 0);
    assign q_head       = qHead;
    assign q_tail       = qTail;
    assign q_dout       = qMem[qHead];
    assign q_probe_dout = qMem[q_probe_idx];

    always @(posedge clk) begin
        if (!reset || q_flush) begin
            qHead <= '0;
            qTail <= '0;
            qCnt  <= 0;
        end else begin
            if (q_probe_push) qMem[q_probe_idx] <= q_probe_din;
            if (q_push && qCnt < DEPTH) begin
                qMem[qTail] <= q_data;
                qTail <= qTail + 4'd1;
            end
            if (q_pop && qCnt > 0) qHead <= qHead + 4'd1;
            qCnt <= qCnt + ((q_push && qCnt < DEPTH) ? 1 : 0) - ((q_pop && qCnt > 0) ? 1 : 0);
        end
    end

    int tests = 0;
    int fails = 0;
    bit armed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference ROB: an ordered list of live entries, each remembering the tag it was given
    typedef struct {int tag; int dest; int res; bit done;} ent_t;
    ent_t rob[$];
    int tailTag = 0, phase = 0, cnt16 = 0, g, occIdx, gTagM, gResM, dDest;
    bit rrM = 0, errExp = 0, eRst, eGate, eDr, ePush, eProbe, eCv, ePop, eFreq;

    initial begin
        forever begin
            @(negedge clk);
            eRst  = (reset === 1'b1);
            eFreq = flush_req;
            eGate = eRst && phase == 0 && !flush_req;
            eDr   = eGate && rob.size() < DEPTH;
            ePush = eDr && disp_valid;
            dDest = int'(disp_dest);
            g = -1;
            if (eGate) begin
                if (wb0_valid && wb1_valid) g = rrM ? 1 : 0;
                else if (wb0_valid) g = 0;
                else if (wb1_valid) g = 1;
            end
            gTagM  = (g == 1) ? int'(wb1_tag) : int'(wb0_tag);
            gResM  = (g == 1) ? int'(wb1_result) : int'(wb0_result);
            occIdx = -1;
            foreach (rob[k]) if (rob[k].tag == gTagM) occIdx = k;
            eProbe = (g >= 0) && (occIdx >= 0);
            eCv    = eGate && rob.size() > 0 && rob[0].done;
            ePop   = eCv && commit_ready;
            if (armed) begin
                chk("disp_ready", disp_ready, eDr);
                if (eDr) chk("disp_tag", disp_tag, tailTag);
                chk("q_push", q_push, ePush);
                if (ePush) chk("q_data", q_data, dDest << RW);
                chk("wb0_ack", wb0_ack, g == 0);
                chk("wb1_ack", wb1_ack, g == 1);
                chk("q_probe_push", q_probe_push, eProbe);
                if (eProbe) begin
                    chk("q_probe_idx", q_probe_idx, gTagM);
                    chk("q_probe_din", q_probe_din, (1 << (EW-1)) | (rob[occIdx].dest << RW) | gResM);
                end
                chk("wb_err", wb_err, errExp);
                chk("commit_valid", commit_valid, eCv);
                if (eCv) begin
                    chk("commit_dest", commit_dest, rob[0].dest);
                    chk("commit_result", commit_result, rob[0].res);
                end
                chk("q_pop", q_pop, ePop);
                chk("commit_count", commit_count, cnt16);
                chk("q_flush", q_flush, eRst && phase == 1);
                chk("busy_flush", busy_flush, phase != 0);
            end
            @(posedge clk);
            if (!eRst) begin
                rob.delete();
                tailTag = 0; phase = 0; cnt16 = 0; rrM = 0; errExp = 0;
            end else begin
                if (eProbe) begin
                    rob[occIdx].done = 1'b1;
                    rob[occIdx].res  = gResM;
                end
                if (ePop) begin
                    void'(rob.pop_front());
                    cnt16 = (cnt16 + 1) & 16'hFFFF;
                end
                if (ePush) begin
                    rob.push_back('{tailTag, dDest, 0, 1'b0});
                    tailTag = (tailTag + 1) % DEPTH;
                end
                errExp = (g >= 0) && (occIdx < 0);
                if (g >= 0) rrM = (g == 0);
                case (phase)
                    0: if (eFreq) phase = 1;
                    1: begin phase = 2; rob.delete(); tailTag = 0; end
                    default: phase = 0;
                endcase
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic flushSeq(input string tag);
        flush_req = 1'b1;
        @(negedge clk);
        chk({tag, "_req_rdy"}, disp_ready, 0);
        chk({tag, "_req_qflush"}, q_flush, 0);
        tick();
        flush_req = 1'b0;
        @(negedge clk);
        chk({tag, "_fl_qflush"}, q_flush, 1);
        chk({tag, "_fl_busy"}, busy_flush, 1);
        chk({tag, "_fl_rdy"}, disp_ready, 0);
        tick();
        @(negedge clk);
        chk({tag, "_rc_qflush"}, q_flush, 0);
        chk({tag, "_rc_busy"}, busy_flush, 1);
        chk({tag, "_rc_rdy"}, disp_ready, 0);
        tick();
        @(negedge clk);
        chk({tag, "_run_busy"}, busy_flush, 0);
        chk({tag, "_run_rdy"}, disp_ready, 1);
        chk({tag, "_run_tag"}, disp_tag, 0);
    endtask

    initial begin
        reset = 1'b0; disp_valid = 0; disp_dest = '0; commit_ready = 0; flush_req = 0;
        wb0_valid = 0; wb0_tag = '0; wb0_result = '0;
        wb1_valid = 0; wb1_tag = '0; wb1_result = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        armed = 1;

        // Dispatch three ops, complete them out of order, commit in order
        disp_valid = 1; disp_dest = 5'd1;
        @(negedge clk); chk("t1_tag0", disp_tag, 0); chk("t1_rdy", disp_ready, 1);
        tick(); disp_dest = 5'd2;
        @(negedge clk); chk("t1_tag1", disp_tag, 1);
        tick(); disp_dest = 5'd3;
        @(negedge clk); chk("t1_tag2", disp_tag, 2);
        tick(); disp_valid = 0;
        wb1_valid = 1; wb1_tag = 4'd1; wb1_result = 8'hAA;
        @(negedge clk); chk("t1_wb1_ack", wb1_ack, 1); chk("t1_cv_a", commit_valid, 0);
        tick(); wb1_valid = 0;
        wb0_valid = 1; wb0_tag = 4'd0; wb0_result = 8'h55; commit_ready = 1;
        @(negedge clk); chk("t1_cv_same_cycle", commit_valid, 0);
        tick(); wb0_valid = 0;
        @(negedge clk); chk("t1_cv0", commit_valid, 1); chk("t1_dest0", commit_dest, 1); chk("t1_res0", commit_result, 8'h55);
        tick();
        @(negedge clk); chk("t1_cv1", commit_valid, 1); chk("t1_dest1", commit_dest, 2); chk("t1_res1", commit_result, 8'hAA);
        tick();
        @(negedge clk); chk("t1_cv_stop", commit_valid, 0); chk("t1_count", commit_count, 2);
        tick(); commit_ready = 0;

        // Reset forces handshakes low, then round-robin between both writeback units
        reset = 0; disp_valid = 1; commit_ready = 1;
        @(negedge clk); chk("t2_rst_rdy", disp_ready, 0); chk("t2_rst_cv", commit_valid, 0);
        tick(); reset = 1; commit_ready = 0; disp_dest = 5'd7;
        @(negedge clk); chk("t2_tag0", disp_tag, 0); chk("t2_count0", commit_count, 0);
        tick(); disp_dest = 5'd8;
        tick(); disp_valid = 0;
        wb0_valid = 1; wb0_tag = 4'd0; wb0_result = 8'h11;
        wb1_valid = 1; wb1_tag = 4'd1; wb1_result = 8'h22;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t2_rr_ack0", wb0_ack, (i % 2 == 0) ? 1 : 0);
            chk("t2_rr_ack1", wb1_ack, (i % 2 == 1) ? 1 : 0);
            tick();
        end
        wb0_valid = 0; wb1_valid = 0; commit_ready = 1;
        tick(); tick(); commit_ready = 0;

        // Fill all 16 entries starting at index 2, then free one with dispatch held
        disp_valid = 1;
        for (int i = 0; i < 16; i++) begin
            disp_dest = DW'(i);
            tick();
        end
        wb0_valid = 1; wb0_tag = 4'd2; wb0_result = 8'h77;
        @(negedge clk); chk("t3_full_rdy", disp_ready, 0); chk("t3_full_ack", wb0_ack, 1);
        tick(); wb0_valid = 0; commit_ready = 1;
        @(negedge clk); chk("t3_cv", commit_valid, 1); chk("t3_pop_rdy", disp_ready, 0);
        tick(); commit_ready = 0;
        @(negedge clk); chk("t3_rdy_after", disp_ready, 1); chk("t3_tag_reuse", disp_tag, 2);
        tick(); disp_valid = 0;
        flushSeq("t3");
        tick();

        // Twenty dispatches with trailing writebacks and commits so the tail wraps 15 -> 0
        disp_valid = 1; commit_ready = 1;
        for (int i = 0; i < 20; i++) begin
            disp_dest  = DW'(i);
            wb0_valid  = (i >= 3);
            wb0_tag    = AW'(i - 3);
            wb0_result = RW'(i);
            tick();
        end
        disp_valid = 0; commit_ready = 0;
        wb0_valid = 1; wb0_tag = 4'd0; wb0_result = 8'h3C;
        @(negedge clk); chk("t4_wrap_ack", wb0_ack, 1); chk("t4_wrap_probe", q_probe_push, 1); chk("t4_wrap_cv", commit_valid, 1);
        tick(); wb0_tag = 4'd9; wb0_result = 8'h99;
        @(negedge clk); chk("t4_err_pre", wb_err, 0); chk("t4_bad_ack", wb0_ack, 1); chk("t4_bad_probe", q_probe_push, 0);
        tick(); wb0_valid = 0;
        @(negedge clk); chk("t4_err_pulse", wb_err, 1);
        tick(); commit_ready = 1;
        @(negedge clk); chk("t4_err_clear", wb_err, 0); chk("t4_commit_res", commit_result, 8'h3C); chk("t4_commit_dest", commit_dest, 16);
        tick(); commit_ready = 0; disp_valid = 1;
        tick(); tick(); disp_valid = 0;

        // Flush with five live entries
        flushSeq("t5");
        tick();

        // Reset landing in FLUSH
        flush_req = 1;
        tick(); flush_req = 0; reset = 0;
        @(negedge clk); chk("t6_qflush_forced", q_flush, 0);
        tick(); reset = 1;
        @(negedge clk); chk("t6_busy", busy_flush, 0); chk("t6_count", commit_count, 0); chk("t6_rdy", disp_ready, 1);
        tick();

        // Randomised traffic against the reference model
        for (int i = 0; i < 4000; i++) begin
            reset        = ($urandom_range(0, 999) != 0);
            flush_req    = ($urandom_range(0, 59) == 0);
            disp_valid   = ($urandom_range(0, 2) != 0);
            disp_dest    = DW'($urandom);
            commit_ready = ($urandom_range(0, 3) != 0);
            wb0_valid    = $urandom_range(0, 1) == 1;
            wb1_valid    = $urandom_range(0, 1) == 1;
            wb0_tag      = AW'(int'(q_head) + $urandom_range(0, 17));
            wb1_tag      = AW'(int'(q_head) + $urandom_range(0, 17));
            wb0_result   = RW'($urandom);
            wb1_result   = RW'($urandom);
            tick();
        end
        reset = 1; flush_req = 0; disp_valid = 0; wb0_valid = 0; wb1_valid = 0; commit_ready = 0;
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
